mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator sitting between the multicycle RISC-V core and the unified word-addressed data memory. It accepts one byte, halfword or word request from the core and drives the memory port (`mem_a`, `mem_we`, `mem_wd`, `mem_rd`). Sub-word stores are done as read-modify-write on the word-only memory. Loads are lane-extracted and sign- or zero-extended. Misaligned or reserved-size requests are rejected without touching memory.

## Interface
- `ADDR_W`, 16, byte-address width of the memory port.
- `DATA_W`, 32, data width; fixed at 32, other values unsupported.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core request strobe.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid & req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  zero-extend loads; ignored for word loads and for stores.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned or reserved size; valid with `rsp_valid`.
- `mem_a`  out  ADDR_W  memory byte address, always word-aligned (low 2 bits 0).
- `mem_we`  out  1  memory write enable.
- `mem_wd`  out  32  memory write data.
- `mem_rd`  in  32  memory read data; combinational from `mem_a`.

## Operation
- All request fields are captured into internal registers on accept. Core inputs are don't-care afterwards.
- FSM states are IDLE, READ, WRITE and RESP. Each state lasts one cycle except IDLE.
- Error check on accept:
  - Half with `addr[0]`=1 is an error.
  - Word with `addr[1:0]`≠0 is an error.
  - Size 11 is an error.
  - On error: IDLE→RESP with `rsp_err`=1. No memory cycle is issued.
- Load: IDLE→READ→RESP.
  - READ drives `mem_a`={addr[15:2],00}.
  - `mem_rd` is registered at the end of READ.
- Word store: IDLE→WRITE→RESP. `mem_wd`=wdata.
- Byte or half store: IDLE→READ→WRITE→RESP.
  - WRITE drives the read word with the target lane(s) replaced by `wdata[7:0]` / `wdata[15:0]`.
- Lane selection is little-endian.
  - Byte lane = `addr[1:0]`.
  - Half lane = `addr[1]`.
  - Loads sign-extend from bit 7/15 unless `req_unsigned`.
- `mem_we` is a decode of state==WRITE only. The memory commits the write at the rising edge that ends WRITE.
- `mem_a` equals the aligned captured address in READ and WRITE, and 0 otherwise. `mem_wd` is 0 outside WRITE.
- RESP pulses `rsp_valid` for exactly one cycle, then the FSM returns to IDLE. There is no response backpressure.
- Reset values: state IDLE; `req_ready`=1; `rsp_valid`=0; `rsp_rdata`=0; `rsp_err`=0; `mem_a`=0; `mem_we`=0; `mem_wd`=0.

## Timing
- Accept edge = cycle 0. `rsp_valid` is high in cycle:
  - 1 for errors,
  - 2 for loads and word stores,
  - 3 for sub-word stores.
- `req_ready` is low from cycle 1 until the FSM re-enters IDLE. The next request can be accepted at the end of the cycle after RESP.
- Peak throughput: one load per 3 cycles; one sub-word store per 4 cycles.
- `req_valid` while not ready is ignored; it is not queued.
- Reset asserted in any state takes effect immediately (asynchronous):
  - `mem_we` drops at once, so a WRITE interrupted before its closing edge does not commit.
  - No `rsp_valid` is produced for the aborted request.
- Reset release: the first accept is possible on the first rising edge with `rst`=1.

## Test plan
- Memory word at 0x0010 = 0x8081F2A4.
  - lb 0x0011 → `rsp_rdata`=0xFFFFFFF2 in cycle 2.
  - lbu 0x0013 → 0x00000080.
  - lw 0x0010 → 0x8081F2A4.
- Same word:
  - lh 0x0012 → 0xFFFF8081.
  - lhu 0x0012 → 0x00008081.
  - lhu 0x0010 → 0x0000F2A4.
- sb 0x0012, wdata 0x12345655 → memory word becomes 0x8055F2A4.
  - `mem_we` high exactly one cycle (cycle 2).
  - `rsp_valid` in cycle 3.
- sw 0x0014, 0xDEADBEEF → no READ state; `mem_we` high in cycle 1 only; `rsp_valid` in cycle 2; word reads back 0xDEADBEEF.
- Error requests:
  - lw 0x0016 → `rsp_err`=1, `rsp_rdata`=0, `rsp_valid` in cycle 1.
  - size 11 → `rsp_err`=1.
  - `mem_we` never asserted and `mem_a` stays 0 throughout.
- Reset pulled low mid-WRITE of sh 0x0010 → `mem_we` falls immediately; memory word unchanged; no `rsp_valid`; `req_ready`=1 after release.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response and memory-port bundle for the load/store unit.
// slave = the load/store unit; master = core request side plus the data memory.
// Memory read data is combinational from mem_a.
interface mem_access_unit_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_we;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_we, mem_wd
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_we, mem_wd
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator: byte/half/word access to a word-only memory, sub-word stores via read-modify-write.
// Latency accept->rsp_valid: 1 cycle on error, 2 for loads and word stores, 3 for sub-word stores.
// One request in flight; req_ready only in IDLE, busy-time requests ignored, no response backpressure.
module mem_access_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              req_err;
    logic [DATA_W-1:0] merged;
    logic [7:0]        load_b;
    logic [15:0]       load_h;
    logic [DATA_W-1:0] load_v;

    // Alignment / size legality of the incoming request
    always_comb begin
        req_err = 1'b0;
        case (bus.req_size)
            2'b01:   req_err = bus.req_addr[0];
            2'b10:   req_err = |bus.req_addr[1:0];
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end

    // Next-state and request capture; mem_rd is latched at the end of READ
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    err_d   = req_err;
                    if (req_err)
                        state_d = S_RESP;
                    else if (bus.req_we && bus.req_size == 2'b10)
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ: begin
                rdata_d = bus.mem_rd;
                state_d = we_q ? S_WRITE : S_RESP;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Store word: sub-word lanes spliced into the word read in READ (little-endian)
    always_comb begin
        merged = rdata_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Load lane extraction with sign/zero extension
    always_comb begin
        load_b = rdata_q[{addr_q[1:0], 3'b000} +: 8];
        load_h = rdata_q[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_v = uns_q ? {24'h0, load_b} : {{24{load_b[7]}}, load_b};
            2'b01:   load_v = uns_q ? {16'h0, load_h} : {{16{load_h[15]}}, load_h};
            default: load_v = rdata_q;
        endcase
    end

    // Output decode from state; memory port idles at zero
    always_comb begin
        bus.req_ready = (state_q == S_IDLE);
        bus.rsp_valid = (state_q == S_RESP);
        bus.rsp_err   = (state_q == S_RESP) && err_q;
        bus.rsp_rdata = (state_q == S_RESP && !err_q && !we_q) ? load_v : '0;
        bus.mem_we    = (state_q == S_WRITE);
        bus.mem_wd    = (state_q == S_WRITE) ? merged : '0;
        bus.mem_a     = (state_q == S_READ || state_q == S_WRITE) ?
                        {addr_q[ADDR_W-1:2], 2'b00} : '0;
    end

    // State and captured-request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed loads/stores/errors, reset during WRITE, then random traffic.
// Expected values come from a byte-level reference memory and timing table kept here.
// Memory model commits writes on the rising edge while mem_we is high.
module tb_mem_access_unit;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mem_access_unit_if #(.ADDR_W(16)) bus();

    mem_access_unit #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory: preload port used only during reset
    logic [31:0] mem [0:16383];
    logic        pre_we;
    logic [13:0] pre_a;
    logic [31:0] pre_d;
    always @(posedge clk) begin
        if (pre_we)
            mem[pre_a] <= pre_d;
        else if (bus.mem_we)
            mem[bus.mem_a[15:2]] <= bus.mem_wd;
    end
    assign bus.mem_rd = mem[bus.mem_a[15:2]];

    // Reference memory for addresses 0x00..0x3F
    logic [31:0] ref_mem [0:15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [15:0] a, input logic [31:0] wd,
                          output logic [31:0] rd_out);
        logic        exp_err;
        int          exp_cyc;
        logic [31:0] exp_rd;
        logic [7:0]  exp_mask;
        logic [31:0] w, sh, new_w;
        logic [15:0] exp_a;
        logic [7:0]  we_mask;
        int          got_cyc;
        logic [31:0] got_rd;
        logic        got_err;
        logic        a_nonzero;
        int          k;

        exp_err  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        w        = ref_mem[a[5:2]];
        new_w    = w;
        exp_a    = {a[15:2], 2'b00};
        exp_rd   = 32'h0;
        exp_mask = 8'h0;
        if (exp_err) begin
            exp_cyc = 1;
        end else if (!we) begin
            exp_cyc = 2;
            sh = w >> (8 * a[1:0]);
            if (sz == 2'b00) begin
                exp_rd = sh & 32'hFF;
                if (!uns && sh[7]) exp_rd = exp_rd | 32'hFFFFFF00;
            end else if (sz == 2'b01) begin
                exp_rd = sh & 32'hFFFF;
                if (!uns && sh[15]) exp_rd = exp_rd | 32'hFFFF0000;
            end else begin
                exp_rd = w;
            end
        end else begin
            for (int n = 0; n < (1 << sz); n++) begin
                k = int'(a[1:0]) + n;
                new_w[8*k +: 8] = wd[8*n +: 8];
            end
            exp_cyc  = (sz == 2'b10) ? 2 : 3;
            exp_mask = 8'h1 << (exp_cyc - 1);
        end

        @(negedge clk);
        check("ready_before_req", bus.req_ready, 1'b1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1;
        // Fields are don't-care after accept; busy-time valid must be ignored
        bus.req_valid    = 1'($urandom);
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = 16'($urandom);
        bus.req_wdata    = $urandom;

        got_cyc   = 0;
        got_rd    = 32'h0;
        got_err   = 1'b0;
        we_mask   = 8'h0;
        a_nonzero = 1'b0;
        for (int c = 1; c <= 5 && got_cyc == 0; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (c == 1) check("ready_low_busy", bus.req_ready, 1'b0);
            if (bus.mem_we) begin
                we_mask[c] = 1'b1;
                check("wr_mem_a", 32'(bus.mem_a), 32'(exp_a));
                check("wr_mem_wd", bus.mem_wd, new_w);
            end else begin
                check("idle_mem_wd", bus.mem_wd, 32'h0);
            end
            if (bus.mem_a != 16'h0) a_nonzero = 1'b1;
            if (bus.rsp_valid) begin
                got_cyc = c;
                got_rd  = bus.rsp_rdata;
                got_err = bus.rsp_err;
                bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;

        check("rsp_cycle", got_cyc, exp_cyc);
        check("rsp_err", got_err, exp_err);
        check("rsp_rdata", got_rd, exp_rd);
        check("mem_we_cycles", {24'h0, we_mask}, {24'h0, exp_mask});
        if (exp_err) check("err_mem_a_zero", a_nonzero, 1'b0);
        if (we && !exp_err) ref_mem[a[5:2]] = new_w;
        check("mem_word", mem[a[15:2]], ref_mem[a[5:2]]);
        rd_out = got_rd;

        @(posedge clk);
        #1;
        check("rsp_one_pulse", bus.rsp_valid, 1'b0);
        check("ready_after_resp", bus.req_ready, 1'b1);
    endtask

    logic [31:0] rd;
    logic [31:0] v;

    initial begin
        rst              = 1'b0;
        pre_we           = 1'b0;
        pre_a            = '0;
        pre_d            = '0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        // Preload memory while in reset
        for (int i = 0; i < 16; i++) begin
            v = (i == 4) ? 32'h8081F2A4 : $urandom;
            ref_mem[i] = v;
            @(negedge clk);
            pre_we = 1'b1;
            pre_a  = 14'(i);
            pre_d  = v;
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;

        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err", bus.rsp_err, 1'b0);
        check("rst_mem_a", 32'(bus.mem_a), 32'h0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_wd", bus.mem_wd, 32'h0);

        @(negedge clk);
        rst = 1'b1;

        // Directed loads from word 0x10
        do_req(1'b0, 2'b00, 1'b0, 16'h0011, 32'h0, rd); check("lb_0011", rd, 32'hFFFFFFF2);
        do_req(1'b0, 2'b00, 1'b1, 16'h0013, 32'h0, rd); check("lbu_0013", rd, 32'h00000080);
        do_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, rd); check("lw_0010", rd, 32'h8081F2A4);
        do_req(1'b0, 2'b01, 1'b0, 16'h0012, 32'h0, rd); check("lh_0012", rd, 32'hFFFF8081);
        do_req(1'b0, 2'b01, 1'b1, 16'h0012, 32'h0, rd); check("lhu_0012", rd, 32'h00008081);
        do_req(1'b0, 2'b01, 1'b1, 16'h0010, 32'h0, rd); check("lhu_0010", rd, 32'h0000F2A4);

        // Stores
        do_req(1'b1, 2'b00, 1'b0, 16'h0012, 32'h12345655, rd);
        check("sb_0012_word", mem[4], 32'h8055F2A4);
        do_req(1'b1, 2'b10, 1'b0, 16'h0014, 32'hDEADBEEF, rd);
        do_req(1'b0, 2'b10, 1'b0, 16'h0014, 32'h0, rd); check("sw_readback", rd, 32'hDEADBEEF);

        // Errors
        do_req(1'b0, 2'b10, 1'b0, 16'h0016, 32'h0, rd);
        do_req(1'b0, 2'b11, 1'b0, 16'h0010, 32'h0, rd);
        do_req(1'b1, 2'b01, 1'b0, 16'h0011, 32'h5A5A5A5A, rd);

        // Reset pulled low during the WRITE of sh 0x0010
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'b01;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 16'h0010;
        bus.req_wdata    = 32'h0000BEEF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_write", bus.mem_we, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_we_drop", bus.mem_we, 1'b0);
        check("abort_ready", bus.req_ready, 1'b1);
        check("abort_no_rsp", bus.rsp_valid, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("abort_rst_rsp", bus.rsp_valid, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        check("abort_mem_kept", mem[4], ref_mem[4]);
        @(posedge clk);
        #1;
        check("abort_rel_rsp", bus.rsp_valid, 1'b0);
        check("abort_rel_ready", bus.req_ready, 1'b1);
        do_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, rd); check("abort_word", rd, 32'h8055F2A4);

        // Random traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom),
                   16'($urandom_range(0, 63)), $urandom, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
